game_mode_fsm: RTL and testbench
================================

Name: game_mode_fsm

Overview:
Top-level game control FSM for the snake game, parametrised in the number of selectable game modes, lives per game, respawn delay and menu idle timeout.
- Sequences intro -> menu -> play -> win/lose.
- Adds pause/resume, multi-life play with a timed respawn, and a menu idle timeout.
- Does its own rising-edge detection on buttons.
- Sits between the button debouncers, the game-logic event sources (collision, timer, score) and the display/render blocks, which consume state, mode and lives_left.

Parameters:
NUM_MODES, 3, number of selectable game modes (1..8); width of btn_sel.
LIVES, 3, lives per game (1..15).
RESPAWN_CYCLES, 50000000, cycles spent in RESPAWN before play resumes (>=1).
IDLE_TIMEOUT, 0, cycles in WAIT with no selection before returning to START; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
btn_sel  input  NUM_MODES  debounced mode-select buttons, bit i selects mode i
btn_pause  input  1  debounced pause/resume button
btn_restart  input  1  debounced restart button
hit_wall  input  1  game event: collision with wall
hit_body  input  1  game event: collision with own body
death  input  1  game event: other death cause
win  input  1  game event: win condition reached
finish  input  1  intro animation finished
state  output  3  current state (encoding below)
mode  output  max(1,$clog2(NUM_MODES))  selected game mode index
lives_left  output  4  remaining lives
game_active  output  1  high only in PLAY
paused  output  1  high only in PAUSE

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst; all registers update only on the clk rising edge.
- State encoding: START=0, WAIT=1, PLAY=2, PAUSE=3, RESPAWN=4, WIN=5, LOSE=6. Value 7 is illegal and goes to START on the next clock.
- Reset values: state=START, mode=0, lives_left=LIVES, game_active=0, paused=0, all counters 0.
- Button edge registers reset to all-ones, so a button held through reset is ignored until it is released.
- Button edge: edge(x) = x & ~x_q, where x_q is x registered every cycle.
- The state register updates on the same clock edge at which an edge or event is first sampled high: one-cycle latency from input to state.
- Level events (hit_wall, hit_body, death, win, finish) are sampled as levels, not edges.
- fail = hit_wall | hit_body | death.
- game_active and paused are decoded combinationally from the state register.

Transitions:
- START: finish -> WAIT, clear idle counter.
- WAIT, on an edge on any btn_sel bit:
  - Lowest set index i wins when several bits rise together.
  - mode<=i, lives_left<=LIVES, -> PLAY.
- WAIT, otherwise (IDLE_TIMEOUT>0):
  - Idle counter increments each cycle.
  - When it reaches IDLE_TIMEOUT-1 with no selection -> START.
  - A selection on that same cycle has priority over the timeout.
- PLAY, priority order:
  1. fail with lives_left==1 -> LOSE, lives_left<=0.
  2. fail with lives_left>1 -> RESPAWN, lives_left<=lives_left-1, respawn counter<=0.
  3. win -> WIN.
  4. edge(btn_pause) -> PAUSE.
  5. Otherwise stay in PLAY.
  - fail and win asserted together counts as fail.
- PAUSE:
  - edge(btn_restart) -> START; this has priority over pause.
  - edge(btn_pause) -> PLAY.
  - fail and win are ignored.
  - mode and lives_left are held.
- RESPAWN:
  - Counter increments each cycle; at count RESPAWN_CYCLES-1 -> PLAY.
  - Time spent in RESPAWN is exactly RESPAWN_CYCLES cycles.
  - fail, win and pause are ignored.
  - edge(btn_restart) -> START.
- WIN / LOSE: edge(btn_restart) -> START; all other inputs are ignored.
- mode changes only on the WAIT->PLAY transition.
- lives_left changes only on WAIT->PLAY (reload to LIVES) and on a fail in PLAY (decrement).
- lives_left never underflows.
- Counters are sized to hold RESPAWN_CYCLES and IDLE_TIMEOUT, saturate never, and are cleared on every state entry.
- Reset mid-operation (any state): the next state is START with all reset values; no partial update.

Test Plan:
1. Reset with btn_sel[0] held, then finish=1 -> state=1. No transition until btn_sel[0] is released and pressed again; then state=2, mode=0, lives_left=3.
2. In WAIT, btn_sel=3'b110 rises in one cycle -> mode=1, state=2 on the next clock. Hold btn_sel high: no further effect.
3. PLAY with LIVES=3: pulse hit_body -> state=4, lives_left=2. After exactly RESPAWN_CYCLES (bench value 8) -> state=2. Repeat twice: the third fail gives state=6, lives_left=0.
4. PLAY: press btn_pause -> state=3, paused=1. Assert death while paused -> no change. Press btn_pause -> state=2. Assert win and hit_wall on the same cycle -> fail path taken (state=4 or 6, not 5).
5. IDLE_TIMEOUT=10: enter WAIT with no presses -> state=0 exactly 10 cycles after WAIT entry. Press btn_sel[2] on the 10th cycle -> state=2, mode=2 instead.
6. In WIN, press btn_restart -> state=0. Drive rst=0 for one cycle while in RESPAWN -> state=0, lives_left=3, mode=0 on that edge.

Source files
------------

// File: rtl/game_mode_fsm.sv
// Top-level snake game control FSM: intro, mode menu with idle timeout, play with
// pause and multi-life respawn, and win/lose screens. Buttons are edge-detected here.
module game_mode_fsm #(
   parameter int NUM_MODES      = 3,
   parameter int LIVES          = 3,
   parameter int RESPAWN_CYCLES = 50000000,
   parameter int IDLE_TIMEOUT   = 0,
   localparam int MODE_W        = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_MODES-1:0] btn_sel,
   input  logic                 btn_pause,
   input  logic                 btn_restart,
   input  logic                 hit_wall,
   input  logic                 hit_body,
   input  logic                 death,
   input  logic                 win,
   input  logic                 finish,
   output logic [2:0]           state,
   output logic [MODE_W-1:0]    mode,
   output logic [3:0]           lives_left,
   output logic                 game_active,
   output logic                 paused
);

   localparam int CNT_MAX   = (RESPAWN_CYCLES > IDLE_TIMEOUT) ? RESPAWN_CYCLES : IDLE_TIMEOUT;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int IDLE_LAST = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] RESP_END = CNT_W'(RESPAWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] IDLE_END = CNT_W'(IDLE_LAST);
   localparam logic [3:0]       LIVES_V  = 4'(LIVES);

   typedef enum logic [2:0] {
      ST_START   = 3'd0,
      ST_WAIT    = 3'd1,
      ST_PLAY    = 3'd2,
      ST_PAUSE   = 3'd3,
      ST_RESPAWN = 3'd4,
      ST_WIN     = 3'd5,
      ST_LOSE    = 3'd6
   } state_e;

   state_e               state_q, state_d;
   logic [MODE_W-1:0]    mode_q, mode_d;
   logic [3:0]           lives_q, lives_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [NUM_MODES-1:0] sel_q;
   logic                 pause_q, restart_q;

   logic [NUM_MODES-1:0] sel_edge;
   logic                 pause_edge, restart_edge, fail;
   logic [MODE_W-1:0]    sel_idx;

   assign sel_edge     = btn_sel & ~sel_q;
   assign pause_edge   = btn_pause & ~pause_q;
   assign restart_edge = btn_restart & ~restart_q;
   assign fail         = hit_wall | hit_body | death;

   // Scan downwards so the lowest rising index is the last one written.
   always_comb begin
      sel_idx = '0;
      for (int i = NUM_MODES - 1; i >= 0; i--) begin
         if (sel_edge[i]) sel_idx = MODE_W'(i);
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      lives_d = lives_q;
      cnt_d   = '0;
      case (state_q)
         ST_START: if (finish) state_d = ST_WAIT;
         ST_WAIT: begin
            if (|sel_edge) begin
               state_d = ST_PLAY;
               mode_d  = sel_idx;
               lives_d = LIVES_V;
            end else if (IDLE_TIMEOUT > 0) begin
               if (cnt_q == IDLE_END) state_d = ST_START;
               else                   cnt_d   = cnt_q + 1'b1;
            end
         end
         ST_PLAY: begin
            if (fail) begin
               if (lives_q <= 4'd1) begin
                  state_d = ST_LOSE;
                  lives_d = 4'd0;
               end else begin
                  state_d = ST_RESPAWN;
                  lives_d = lives_q - 4'd1;
               end
            end else if (win) begin
               state_d = ST_WIN;
            end else if (pause_edge) begin
               state_d = ST_PAUSE;
            end
         end
         ST_PAUSE: begin
            if (restart_edge)    state_d = ST_START;
            else if (pause_edge) state_d = ST_PLAY;
         end
         ST_RESPAWN: begin
            if (restart_edge)           state_d = ST_START;
            else if (cnt_q == RESP_END) state_d = ST_PLAY;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         ST_WIN, ST_LOSE: if (restart_edge) state_d = ST_START;
         default: state_d = ST_START;
      endcase
   end

   // Edge registers reset high so a button held through reset must be released first.
   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_START;
         mode_q    <= '0;
         lives_q   <= LIVES_V;
         cnt_q     <= '0;
         sel_q     <= '1;
         pause_q   <= 1'b1;
         restart_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         lives_q   <= lives_d;
         cnt_q     <= cnt_d;
         sel_q     <= btn_sel;
         pause_q   <= btn_pause;
         restart_q <= btn_restart;
      end
   end

   assign state       = state_q;
   assign mode        = mode_q;
   assign lives_left  = lives_q;
   assign game_active = (state_q == ST_PLAY);
   assign paused      = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_game_mode_fsm.sv
// Directed bench for game_mode_fsm with NUM_MODES=3, LIVES=3, RESPAWN_CYCLES=8,
// IDLE_TIMEOUT=10; expected values are hand-derived from the state sequencing rules.
module tb_game_mode_fsm;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] btn_sel;
   logic       btn_pause, btn_restart;
   logic       hit_wall, hit_body, death, win, finish;
   logic [2:0] state;
   logic [1:0] mode;
   logic [3:0] lives_left;
   logic       game_active, paused;

   int checks   = 0;
   int failures = 0;

   game_mode_fsm #(
      .NUM_MODES      (3),
      .LIVES          (3),
      .RESPAWN_CYCLES (8),
      .IDLE_TIMEOUT   (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_sel     (btn_sel),
      .btn_pause   (btn_pause),
      .btn_restart (btn_restart),
      .hit_wall    (hit_wall),
      .hit_body    (hit_body),
      .death       (death),
      .win         (win),
      .finish      (finish),
      .state       (state),
      .mode        (mode),
      .lives_left  (lives_left),
      .game_active (game_active),
      .paused      (paused)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, then settle 1 time unit before driving or sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0; btn_sel = 3'b001; btn_pause = 1'b0; btn_restart = 1'b0;
      hit_wall = 1'b0; hit_body = 1'b0; death = 1'b0; win = 1'b0; finish = 1'b0;
      step(); step();
      check("rst_state", state, 0);
      check("rst_mode", mode, 0);
      check("rst_lives", lives_left, 3);
      check("rst_active", game_active, 0);
      check("rst_paused", paused, 0);

      // Button held through reset is ignored until released and pressed again.
      rst = 1'b1; finish = 1'b1;
      step();
      check("start_to_wait", state, 1);
      finish = 1'b0;
      step();
      check("held_sel_ignored", state, 1);
      btn_sel = 3'b000;
      step();
      check("released_sel", state, 1);
      btn_sel = 3'b001;
      step();
      check("sel0_play", state, 2);
      check("sel0_mode", mode, 0);
      check("sel0_lives", lives_left, 3);
      check("play_active", game_active, 1);
      btn_sel = 3'b000;

      // Three fails with respawns of exactly 8 cycles.
      hit_body = 1'b1;
      step();
      hit_body = 1'b0;
      check("fail1_respawn", state, 4);
      check("fail1_lives", lives_left, 2);
      check("respawn_inactive", game_active, 0);
      repeat (7) step();
      check("respawn_cycle8", state, 4);
      step();
      check("respawn_done1", state, 2);
      hit_body = 1'b1;
      step();
      hit_body = 1'b0;
      check("fail2_respawn", state, 4);
      check("fail2_lives", lives_left, 1);
      win = 1'b1; btn_pause = 1'b1;
      repeat (7) step();
      win = 1'b0; btn_pause = 1'b0;
      check("respawn_ignores", state, 4);
      step();
      check("respawn_done2", state, 2);
      hit_body = 1'b1;
      step();
      hit_body = 1'b0;
      check("fail3_lose", state, 6);
      check("fail3_lives", lives_left, 0);
      btn_restart = 1'b1;
      step();
      btn_restart = 1'b0;
      check("lose_restart", state, 0);

      // Several selection bits rising together: lowest index wins; holding has no effect.
      finish = 1'b1;
      step();
      finish = 1'b0;
      btn_sel = 3'b110;
      step();
      check("multi_sel_state", state, 2);
      check("multi_sel_mode", mode, 1);
      step();
      check("hold_sel_state", state, 2);
      check("hold_sel_mode", mode, 1);
      btn_sel = 3'b000;

      // Pause, ignored death, resume, then simultaneous win and fail.
      btn_pause = 1'b1;
      step();
      check("pause_state", state, 3);
      check("pause_flag", paused, 1);
      death = 1'b1;
      step();
      death = 1'b0; btn_pause = 1'b0;
      check("pause_ignores_death", state, 3);
      check("pause_lives_held", lives_left, 3);
      step();
      btn_pause = 1'b1;
      step();
      btn_pause = 1'b0;
      check("resume_play", state, 2);
      win = 1'b1; hit_wall = 1'b1;
      step();
      win = 1'b0; hit_wall = 1'b0;
      check("fail_beats_win", state, 4);
      check("fail_beats_win_lives", lives_left, 2);

      // Synchronous reset while in RESPAWN.
      rst = 1'b0;
      step();
      rst = 1'b1;
      check("midrst_state", state, 0);
      check("midrst_lives", lives_left, 3);
      check("midrst_mode", mode, 0);

      // Menu idle timeout of 10 cycles.
      finish = 1'b1;
      step();
      finish = 1'b0;
      repeat (9) step();
      check("idle_cycle9", state, 1);
      step();
      check("idle_timeout", state, 0);

      // Selection on the timeout cycle takes priority.
      finish = 1'b1;
      step();
      finish = 1'b0;
      repeat (9) step();
      btn_sel = 3'b100;
      step();
      btn_sel = 3'b000;
      check("sel_beats_timeout", state, 2);
      check("sel_beats_timeout_mode", mode, 2);

      // WIN ignores pause, restart returns to START.
      win = 1'b1;
      step();
      win = 1'b0;
      check("win_state", state, 5);
      btn_pause = 1'b1; hit_wall = 1'b1;
      step();
      btn_pause = 1'b0; hit_wall = 1'b0;
      check("win_ignores", state, 5);
      btn_restart = 1'b1;
      step();
      btn_restart = 1'b0;
      check("win_restart", state, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
